// File: rtl/srpt_fetch_issue.sv
// srpt_fetch_issue: turns SRPT fetch-queue entries into tagged cache-block DMA
// reads and turns each read completion into an SRPT_DBUFF_UPDATE notification.
module srpt_fetch_issue #(
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned TAG_WIDTH       = 4
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ap_ce,
  input  logic                    ap_start,
  input  logic                    fetch_in_empty_i,
  output logic                    fetch_in_read_en_o,
  input  logic [98:0]             fetch_in_data_i,
  output logic                    dma_r_req_valid_o,
  input  logic                    dma_r_req_ready_i,
  output logic [52+TAG_WIDTH-1:0] dma_r_req_data_o,
  input  logic                    dma_r_resp_valid_i,
  output logic                    dma_r_resp_ready_o,
  input  logic [TAG_WIDTH-1:0]    dma_r_resp_tag_i,
  output logic                    dbuff_notif_valid_o,
  input  logic                    dbuff_notif_ready_i,
  output logic [98:0]             dbuff_notif_data_o,
  output logic [TAG_WIDTH:0]      outstanding_o,
  output logic                    err_o,
  output logic                    ap_idle,
  output logic                    ap_done,
  output logic                    ap_ready
);

  localparam int unsigned CNT_W = TAG_WIDTH + 1;
  localparam int unsigned LEN_W = 7;
  localparam int unsigned OFF_W = 20;
  localparam logic [OFF_W-1:0] BLOCK_BYTES       = 20'd64;
  localparam logic [2:0]       PRIO_DBUFF_UPDATE = 3'b001;

  typedef struct packed {
    logic [9:0]       rsvd_hi;
    logic [2:0]       prio;
    logic [19:0]      granted;
    logic [OFF_W-1:0] dbuffered;
    logic [19:0]      remaining;
    logic             rsvd_lo;
    logic [8:0]       dbuff_id;
    logic [15:0]      rpc_id;
  } entry_t;

  typedef struct packed {
    logic [LEN_W-1:0]     len;
    logic [OFF_W-1:0]     offset;
    logic [8:0]           dbuff_id;
    logic [15:0]          rpc_id;
    logic [TAG_WIDTH-1:0] tag;
  } req_t;

  typedef enum logic {IDLE, REQ} state_t;

  state_t                     state, state_nxt;
  entry_t                     entry;
  entry_t                     notif_q, notif_next;
  req_t                       req_q, req_next;
  logic [MAX_OUTSTANDING-1:0] busy, alloc_vec, free_vec;
  logic [TAG_WIDTH-1:0]       free_tag;
  logic [LEN_W-1:0]           req_len;
  logic                       en, any_free, pop, alloc, req_done;
  logic                       resp_hs, resp_hit, resp_miss;
  logic                       unused_entry_bits;

  logic [15:0]      slot_rpc   [MAX_OUTSTANDING];
  logic [8:0]       slot_dbuff [MAX_OUTSTANDING];
  logic [OFF_W-1:0] slot_off   [MAX_OUTSTANDING];
  logic [LEN_W-1:0] slot_len   [MAX_OUTSTANDING];

  assign entry             = entry_t'(fetch_in_data_i);
  assign unused_entry_bits = ^{entry.rsvd_hi, entry.prio, entry.granted, entry.rsvd_lo};
  assign en                = ap_ce & ap_start;
  assign any_free          = ~(&busy);
  assign req_len           = (entry.remaining >= BLOCK_BYTES) ? LEN_W'(BLOCK_BYTES)
                                                              : entry.remaining[LEN_W-1:0];

  assign dma_r_resp_ready_o = !dbuff_notif_valid_o || dbuff_notif_ready_i;
  assign resp_hs   = en && dma_r_resp_valid_i && dma_r_resp_ready_o;
  assign resp_hit  = resp_hs && busy[dma_r_resp_tag_i];
  assign resp_miss = resp_hs && !busy[dma_r_resp_tag_i];

  assign alloc_vec = alloc ? (MAX_OUTSTANDING'(1) << free_tag) : '0;
  assign free_vec  = resp_hit ? (MAX_OUTSTANDING'(1) << dma_r_resp_tag_i) : '0;

  assign fetch_in_read_en_o = pop;
  assign dma_r_req_data_o   = req_q;
  assign dbuff_notif_data_o = notif_q;
  assign ap_idle  = (state == IDLE) && (outstanding_o == '0) && !dbuff_notif_valid_o;
  assign ap_done  = 1'b1;
  assign ap_ready = 1'b1;

  // Lowest-numbered free tag, taken from the mask registered at cycle start
  always_comb begin
    free_tag = '0;
    for (int i = int'(MAX_OUTSTANDING) - 1; i >= 0; i--) begin
      if (!busy[i]) free_tag = TAG_WIDTH'(i);
    end
  end

  // Issue FSM: pop/allocate in IDLE, hold the request in REQ until accepted
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    alloc     = 1'b0;
    req_done  = 1'b0;
    case (state)
      IDLE: begin
        if (en && !fetch_in_empty_i) begin
          if (entry.remaining == '0) begin
            pop = 1'b1;
          end else if (any_free) begin
            pop       = 1'b1;
            alloc     = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (en && dma_r_req_ready_i) begin
          req_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request and notification payloads
  always_comb begin
    req_next          = '0;
    req_next.len      = req_len;
    req_next.offset   = entry.dbuffered;
    req_next.dbuff_id = entry.dbuff_id;
    req_next.rpc_id   = entry.rpc_id;
    req_next.tag      = free_tag;

    notif_next           = '0;
    notif_next.rpc_id    = slot_rpc[dma_r_resp_tag_i];
    notif_next.dbuff_id  = slot_dbuff[dma_r_resp_tag_i];
    notif_next.dbuffered = slot_off[dma_r_resp_tag_i] + OFF_W'(slot_len[dma_r_resp_tag_i]);
    notif_next.prio      = PRIO_DBUFF_UPDATE;
  end

  // FSM state register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // Outgoing DMA read request
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dma_r_req_valid_o <= 1'b0;
      req_q             <= '0;
    end else if (alloc) begin
      dma_r_req_valid_o <= 1'b1;
      req_q             <= req_next;
    end else if (req_done) begin
      dma_r_req_valid_o <= 1'b0;
    end
  end

  // Per-tag context; only meaningful while the tag is busy, so no reset
  always_ff @(posedge ap_clk) begin
    if (alloc) begin
      slot_rpc[free_tag]   <= entry.rpc_id;
      slot_dbuff[free_tag] <= entry.dbuff_id;
      slot_off[free_tag]   <= entry.dbuffered;
      slot_len[free_tag]   <= req_len;
    end
  end

  // Tag occupancy, in-flight count and sticky spurious-completion flag
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      busy          <= '0;
      outstanding_o <= '0;
      err_o         <= 1'b0;
    end else begin
      busy          <= (busy | alloc_vec) & ~free_vec;
      outstanding_o <= outstanding_o + CNT_W'(alloc) - CNT_W'(resp_hit);
      if (resp_miss) err_o <= 1'b1;
    end
  end

  // Completion notification toward the SRPT scheduler
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dbuff_notif_valid_o <= 1'b0;
      notif_q             <= '0;
    end else if (resp_hit) begin
      dbuff_notif_valid_o <= 1'b1;
      notif_q             <= notif_next;
    end else if (en && dbuff_notif_ready_i) begin
      dbuff_notif_valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/srpt_fetch_issue.md
Name: srpt_fetch_issue

Overview:
- Sits directly downstream of the SRPT fetch queue and consumes the 99-bit entries it writes into the fetch FIFO.
- Turns each entry into one cache-block DMA read request toward host memory and tracks up to MAX_OUTSTANDING in-flight reads by tag.
- On each read completion, emits an SRPT_DBUFF_UPDATE notification back toward the SRPT scheduling logic.

Parameters:
- MAX_OUTSTANDING, 16: number of tag slots. Must equal 2**TAG_WIDTH.
- TAG_WIDTH, 4: width of the DMA tag.

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- ap_ce, ap_start  in  1 each  block enable; all state advances only when both are high
- fetch_in_empty_i  in  1  high = fetch FIFO empty (first-word-fall-through)
- fetch_in_read_en_o  out  1  one-cycle pop strobe
- fetch_in_data_i  in  99  queue entry: RPC_ID[15:0], DBUFF_ID[24:16], REMAINING[45:26], DBUFFERED[65:46], GRANTED[85:66], PRIORITY[88:86]
- dma_r_req_valid_o  out  1  read request valid
- dma_r_req_ready_i  in  1  DMA engine accepts
- dma_r_req_data_o  out  52+TAG_WIDTH  {len[6:0], offset[19:0], dbuff_id[8:0], rpc_id[15:0], tag}
- dma_r_resp_valid_i  in  1  completion valid
- dma_r_resp_ready_o  out  1  completion accept
- dma_r_resp_tag_i  in  TAG_WIDTH  completed tag
- dbuff_notif_valid_o  out  1  notification valid
- dbuff_notif_ready_i  in  1  notification accept
- dbuff_notif_data_o  out  99  queue-entry-format update
- outstanding_o  out  TAG_WIDTH+1  tags currently in flight
- err_o  out  1  sticky spurious-completion flag
- ap_idle, ap_done, ap_ready  out  1 each

Behaviour:
- Reset (async assert, sync release) values:
  - dma_r_req_valid_o=0, dbuff_notif_valid_o=0, err_o=0, outstanding_o=0.
  - All tags free; FSM in IDLE; dma_r_req_data_o=0, dbuff_notif_data_o=0.
- Issue FSM states: IDLE, REQ.
  - IDLE: when !fetch_in_empty_i && any tag free && ap_ce && ap_start:
    - assert fetch_in_read_en_o combinationally for exactly that cycle;
    - latch the entry and allocate the lowest-numbered free tag;
    - go to REQ, with dma_r_req_valid_o=1 from the next cycle.
  - IDLE with entry REMAINING==0: pop it, issue no request, stay in IDLE.
  - REQ: hold dma_r_req_valid_o and dma_r_req_data_o stable until dma_r_req_ready_i. In the accepting cycle, drop valid next cycle and return to IDLE. Back-to-back entries therefore issue at most one per 2 cycles.
- Request fields:
  - len = min(64, REMAINING), 7 bits.
  - offset = DBUFFERED.
  - rpc_id, dbuff_id copied from the entry.
  - The tag slot stores rpc_id, dbuff_id, offset, len.
- Completion path:
  - dma_r_resp_ready_o = !dbuff_notif_valid_o || dbuff_notif_ready_i.
  - On a resp handshake with an outstanding tag: free the tag and register the notification for the next cycle:
    - RPC_ID, DBUFF_ID from the slot;
    - DBUFFERED = offset+len (20-bit, wraps modulo 2^20);
    - PRIORITY = 3'b001 (SRPT_DBUFF_UPDATE);
    - all other bits 0.
  - dbuff_notif_valid_o holds until dbuff_notif_ready_i.
  - Completion for a tag not outstanding: no notification, no state change, err_o set until reset.
- Simultaneous events:
  - A tag freed in cycle N is not allocatable until N+1; allocation uses the free mask registered at the start of the cycle.
  - outstanding_o = previous value + alloc − free; it is unchanged when both occur in the same cycle.
- Full:
  - With all tags in flight, IDLE stalls; fetch_in_read_en_o stays 0.
  - Issue resumes the cycle after a free.
- ap_ce or ap_start low: no pop, no FSM transition, no tag change. Outputs hold their values.
- Reset mid-operation clears all tags and pending valids. Completions arriving after reset are spurious and set err_o.
- ap_idle = (state==IDLE && outstanding_o==0 && !dbuff_notif_valid_o). ap_done=1, ap_ready=1.

Test Plan:
- Entry rpc 1, dbuff 1, REMAINING 1000, DBUFFERED 0, with ready high:
  - read_en pulses once;
  - next cycle request {len 64, offset 0, tag 0};
  - resp tag 0 → notification RPC 1, DBUFFERED 64, PRIORITY 1.
- Entry REMAINING 40, DBUFFERED 960: request len 40, offset 960; completion → notification DBUFFERED 1000.
- 17 entries with no completions: 16 requests with tags 0..15, outstanding_o=16, and 17th not popped. Complete tag 5 → 17th issues with tag 5 one cycle later.
- dbuff_notif_ready_i held low, two completions:
  - first notification holds;
  - dma_r_resp_ready_o=0 blocks the second;
  - release ready → both notifications delivered in order.
- Resp tag 3 when no tag is outstanding: err_o=1, no notification, outstanding_o unchanged.
- Reset asserted while in REQ with 3 tags outstanding: all outputs return to reset values immediately; after release, the next entry gets tag 0.
